q_sweep_sequencer: RTL and testbench
====================================

Name: q_sweep_sequencer

Overview:
Sequences the Q-control loop through a programmable list of Q setpoints. It sits above `top`, drives `q_desired`, `enable`, `start` and a loop reset, and waits for `q_control.converged` or a timeout on each step. After each step it holds for a fixed time, pulses the loop reset, then advances to the next setpoint. It replaces hand-written bench sweeps with synthesizable on-chip characterisation of the resonant front-end.

Parameters:
BUS_WIDTH, 10, width of the Q setpoint and `q_desired` bus
MAX_STEPS, 16, depth of the setpoint table (power of 2, at least 2)
TIMEOUT_CYCLES, 50000, maximum wait cycles per step before it is declared timed out
HOLD_CYCLES, 75, cycles to hold after converge or timeout, before the loop reset
RST_CYCLES, 75, width of the `loop_rst` pulse, in cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  setpoint table write strobe; ignored while `busy`
cfg_addr  in  $clog2(MAX_STEPS)  table write address
cfg_data  in  BUS_WIDTH  setpoint value to write
num_steps  in  $clog2(MAX_STEPS)+1  number of steps in the sweep; sampled on `go`
go  in  1  sweep start pulse; honoured only in IDLE or DONE
abort  in  1  terminates the sweep from any busy state
converged  in  1  convergence flag from `q_control`
q_desired  out  BUS_WIDTH  current setpoint driven to `top`
loop_en  out  1  drives `top` `enable` and `start`
loop_rst  out  1  reset to `top`; OR with the system `rst` externally
step_idx  out  $clog2(MAX_STEPS)  index of the active step
step_done  out  1  one-cycle pulse when a step ends with convergence
step_timeout  out  1  one-cycle pulse when a step ends with a timeout
timeout_cnt  out  $clog2(MAX_STEPS)+1  number of steps that timed out in this sweep
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - Table contents are not reset; the table is a register array.
- All outputs are registered.
- States: IDLE, APPLY, WAIT_CONV, HOLD, RESET, DONE.
- IDLE or DONE:
  - `go` loads `n = num_steps` and clears `step_idx` and `timeout_cnt`.
  - If `n == 0`, go to DONE. Otherwise go to APPLY.
  - `go` in any busy state is ignored.
  - A `num_steps` value above MAX_STEPS is clamped to MAX_STEPS.
- APPLY (1 cycle):
  - `q_desired <= table[step_idx]`, `loop_en <= 1`.
  - Clears the wait counter, then goes to WAIT_CONV.
  - `converged` is not sampled in this state.
  - `q_desired` and `loop_en` are valid 2 cycles after `go`.
- WAIT_CONV:
  - The wait counter increments every cycle.
  - If `converged`: pulse `step_done` and go to HOLD.
  - Else, if the counter equals TIMEOUT_CYCLES-1: pulse `step_timeout`, increment `timeout_cnt`, go to HOLD.
  - If both occur in the same cycle, convergence wins.
- HOLD:
  - Lasts HOLD_CYCLES cycles.
  - `loop_en` and `q_desired` stay unchanged, then go to RESET.
- RESET:
  - `loop_rst = 1` and `loop_en = 0` for RST_CYCLES cycles.
  - On exit: if `step_idx == n-1` go to DONE (`loop_rst` drops), else `step_idx++` and go to APPLY.
- DONE:
  - `done = 1`; `q_desired` holds its last value.
  - Leaves only on `go` or `rst`.
- `abort` in any busy state:
  - Goes to RESET.
  - After the RESET pulse, goes to DONE regardless of `step_idx`.
  - `abort` has priority over every other transition, including a `converged` or timeout decision in the same cycle.
  - No `step_done` or `step_timeout` pulse is issued in that cycle.
- `rst` mid-sweep: immediate return to IDLE with all outputs 0.
- Counters:
  - One shared counter, `$clog2(max(TIMEOUT_CYCLES, HOLD_CYCLES, RST_CYCLES))` bits wide.
  - Cleared on every state entry.
- `timeout_cnt` saturates at MAX_STEPS.

Decomposition:
- Package `q_sweep_pkg`: `state_e` enum and a width helper function for the counter and index widths.
- Sub-module `sp_table`: the MAX_STEPS x BUS_WIDTH register file, with a synchronous write port and a combinational read port.
- The FSM and counters live in `q_sweep_sequencer`.

Test Plan:
All scenarios use TIMEOUT_CYCLES=20, HOLD_CYCLES=3 and RST_CYCLES=2.
1. Basic sweep:
   - Table {40, 80, 120}, `num_steps=3`, `converged` raised 5 cycles after each APPLY.
   - Expect `q_desired` = 40, 80, 120 in order, 3 `step_done` pulses, `timeout_cnt=0`, `done=1`.
   - Expect each step to last 1 + 6 + 3 + 2 = 12 cycles.
2. Timeout:
   - Table {60, 90}, `converged` held at 0.
   - Expect `step_timeout` on the 20th WAIT_CONV cycle of each step and `timeout_cnt=2`.
   - Expect `loop_rst` high for 2 cycles twice, then `done`.
3. `converged` and timeout in the same cycle:
   - Raise `converged` exactly on WAIT_CONV cycle 20.
   - Expect `step_done=1`, `step_timeout=0`, `timeout_cnt` unchanged.
4. Abort:
   - Pulse `abort` during HOLD of step 1 of 4.
   - Expect a 2-cycle `loop_rst`, then `done=1` with `step_idx=1`, and no further APPLY.
5. Edge cases:
   - `num_steps=0` with `go`: expect `done` 1 cycle later and `loop_en` never high.
   - `num_steps=17`: expect the sweep clamped to 16 steps.
   - `cfg_we` while `busy`: expect the table unchanged.
6. Async reset mid-sweep:
   - Assert `rst` during WAIT_CONV.
   - Expect all outputs 0 without waiting for a clock edge.
   - Expect a new `go` to restart at `step_idx=0`.

Source files
------------

// File: rtl/q_sweep_pkg.sv
// Shared definitions for the Q sweep sequencer.
// Contents:
//   state_e      - sequencer FSM states
//   width_for()  - bits needed to count 0..max_count-1 (minimum 1)
//   max3()       - largest of three integers
package q_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_APPLY     = 3'd1,
        ST_WAIT_CONV = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RESET     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    function automatic int width_for(input int max_count);
        int w;
        w = $clog2(max_count);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/q_sweep_sequencer_sp_table.sv
// Setpoint table: MAX_STEPS x BUS_WIDTH register file.
// Contents are deliberately not reset; software loads them before a sweep.
// Ports:
//   clk      - system clock
//   wr_en    - synchronous write enable
//   wr_addr  - write address
//   wr_data  - value written
//   rd_addr  - combinational read address
//   rd_data  - table[rd_addr]
module sp_table #(
    parameter int BUS_WIDTH = 10,
    parameter int MAX_STEPS = 16
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_STEPS)-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]         wr_data,
    input  logic [$clog2(MAX_STEPS)-1:0] rd_addr,
    output logic [BUS_WIDTH-1:0]         rd_data
);

    logic [BUS_WIDTH-1:0] mem_r [MAX_STEPS];

    // synchronous write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/q_sweep_sequencer.sv
// Q sweep sequencer: steps the Q-control loop through a programmable list
// of setpoints. Per step: apply setpoint, wait for convergence or timeout,
// hold, pulse the loop reset, then advance.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   cfg_we/addr/data  - setpoint table write port (ignored while busy)
//   num_steps, go     - sweep length (clamped to MAX_STEPS) and start pulse
//   abort             - ends a running sweep via a final loop-reset pulse
//   converged         - convergence flag from the Q-control loop
//   q_desired         - setpoint driven to the loop
//   loop_en           - loop enable/start
//   loop_rst          - loop reset pulse
//   step_idx          - active step
//   step_done         - one-cycle pulse: step converged
//   step_timeout      - one-cycle pulse: step timed out
//   timeout_cnt       - timed-out steps in this sweep (saturating)
//   busy, done        - sweep running / sweep finished
module q_sweep_sequencer
    import q_sweep_pkg::*;
#(
    parameter int BUS_WIDTH      = 10,
    parameter int MAX_STEPS      = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int HOLD_CYCLES    = 75,
    parameter int RST_CYCLES     = 75
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_STEPS)-1:0] cfg_addr,
    input  logic [BUS_WIDTH-1:0]         cfg_data,
    input  logic [$clog2(MAX_STEPS):0]   num_steps,
    input  logic                         go,
    input  logic                         abort,
    input  logic                         converged,
    output logic [BUS_WIDTH-1:0]         q_desired,
    output logic                         loop_en,
    output logic                         loop_rst,
    output logic [$clog2(MAX_STEPS)-1:0] step_idx,
    output logic                         step_done,
    output logic                         step_timeout,
    output logic [$clog2(MAX_STEPS):0]   timeout_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W = width_for(MAX_STEPS);
    localparam int NUM_W = IDX_W + 1;
    localparam int CNT_W = width_for(max3(TIMEOUT_CYCLES, HOLD_CYCLES, RST_CYCLES));

    localparam logic [NUM_W-1:0] NUM_MAX      = NUM_W'(MAX_STEPS);
    localparam logic [NUM_W-1:0] NUM_ONE      = {{(NUM_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ZERO     = {NUM_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE      = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RST_LAST = CNT_W'(RST_CYCLES - 1);

    state_e               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [NUM_W-1:0]     n_r;
    logic                 aborted_r;
    logic [BUS_WIDTH-1:0] q_desired_r;
    logic                 loop_en_r;
    logic                 loop_rst_r;
    logic [IDX_W-1:0]     step_idx_r;
    logic                 step_done_r;
    logic                 step_timeout_r;
    logic [NUM_W-1:0]     timeout_cnt_r;
    logic                 busy_r;
    logic                 done_r;

    logic [NUM_W-1:0]     n_clamped_s;
    logic                 last_step_s;
    logic                 abortable_s;
    logic [BUS_WIDTH-1:0] rd_data_s;
    logic                 tbl_we_s;

    // table writes are locked out for the whole sweep so a step never
    // sees a setpoint changed underneath it
    assign tbl_we_s = cfg_we & ~busy_r;

    sp_table #(
        .BUS_WIDTH (BUS_WIDTH),
        .MAX_STEPS (MAX_STEPS)
    ) u_sp_table (
        .clk     (clk),
        .wr_en   (tbl_we_s),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (step_idx_r),
        .rd_data (rd_data_s)
    );

    // step-count clamp and per-state decode helpers
    always_comb begin
        n_clamped_s = num_steps;
        last_step_s = 1'b0;
        abortable_s = 1'b0;
        if (num_steps > NUM_MAX) begin
            n_clamped_s = NUM_MAX;
        end else begin
            n_clamped_s = num_steps;
        end
        last_step_s = ({1'b0, step_idx_r} == (n_r - NUM_ONE));
        // RESET is excluded: an abort there only marks the sweep as ending
        abortable_s = (state_r == ST_APPLY) || (state_r == ST_WAIT_CONV) ||
                      (state_r == ST_HOLD);
    end

    // sweep FSM, shared step counter and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            n_r            <= NUM_ZERO;
            aborted_r      <= 1'b0;
            q_desired_r    <= {BUS_WIDTH{1'b0}};
            loop_en_r      <= 1'b0;
            loop_rst_r     <= 1'b0;
            step_idx_r     <= IDX_ZERO;
            step_done_r    <= 1'b0;
            step_timeout_r <= 1'b0;
            timeout_cnt_r  <= NUM_ZERO;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            step_done_r    <= 1'b0;
            step_timeout_r <= 1'b0;
            if (abort && abortable_s) begin
                // abort outranks any converge/timeout decision this cycle
                state_r    <= ST_RESET;
                cnt_r      <= CNT_ZERO;
                aborted_r  <= 1'b1;
                loop_en_r  <= 1'b0;
                loop_rst_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (go) begin
                            n_r           <= n_clamped_s;
                            step_idx_r    <= IDX_ZERO;
                            timeout_cnt_r <= NUM_ZERO;
                            cnt_r         <= CNT_ZERO;
                            aborted_r     <= 1'b0;
                            if (n_clamped_s == NUM_ZERO) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= ST_APPLY;
                                done_r  <= 1'b0;
                                busy_r  <= 1'b1;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_APPLY: begin
                        q_desired_r <= rd_data_s;
                        loop_en_r   <= 1'b1;
                        cnt_r       <= CNT_ZERO;
                        state_r     <= ST_WAIT_CONV;
                    end
                    ST_WAIT_CONV: begin
                        if (converged) begin
                            step_done_r <= 1'b1;
                            cnt_r       <= CNT_ZERO;
                            state_r     <= ST_HOLD;
                        end else if (cnt_r == CNT_TO_LAST) begin
                            step_timeout_r <= 1'b1;
                            if (timeout_cnt_r != NUM_MAX) begin
                                timeout_cnt_r <= timeout_cnt_r + NUM_ONE;
                            end else begin
                                timeout_cnt_r <= timeout_cnt_r;
                            end
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_HOLD;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_r == CNT_HLD_LAST) begin
                            cnt_r      <= CNT_ZERO;
                            loop_en_r  <= 1'b0;
                            loop_rst_r <= 1'b1;
                            state_r    <= ST_RESET;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_RESET: begin
                        if (cnt_r == CNT_RST_LAST) begin
                            cnt_r      <= CNT_ZERO;
                            loop_rst_r <= 1'b0;
                            if (aborted_r || abort || last_step_s) begin
                                state_r   <= ST_DONE;
                                done_r    <= 1'b1;
                                busy_r    <= 1'b0;
                                aborted_r <= 1'b0;
                            end else begin
                                step_idx_r <= step_idx_r + IDX_ONE;
                                state_r    <= ST_APPLY;
                            end
                        end else begin
                            cnt_r     <= cnt_r + CNT_ONE;
                            aborted_r <= aborted_r | abort;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= CNT_ZERO;
                        loop_en_r  <= 1'b0;
                        loop_rst_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q_desired    = q_desired_r;
    assign loop_en      = loop_en_r;
    assign loop_rst     = loop_rst_r;
    assign step_idx     = step_idx_r;
    assign step_done    = step_done_r;
    assign step_timeout = step_timeout_r;
    assign timeout_cnt  = timeout_cnt_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Directed self-checking bench for q_sweep_sequencer
// (TIMEOUT_CYCLES=20, HOLD_CYCLES=3, RST_CYCLES=2).
module tb_q_sweep_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [9:0] cfg_data;
    logic [4:0] num_steps;
    logic       go;
    logic       abort;
    logic       converged;
    logic [9:0] q_desired;
    logic       loop_en;
    logic       loop_rst;
    logic [3:0] step_idx;
    logic       step_done;
    logic       step_timeout;
    logic [4:0] timeout_cnt;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    q_sweep_sequencer #(
        .BUS_WIDTH      (10),
        .MAX_STEPS      (16),
        .TIMEOUT_CYCLES (20),
        .HOLD_CYCLES    (3),
        .RST_CYCLES     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .num_steps    (num_steps),
        .go           (go),
        .abort        (abort),
        .converged    (converged),
        .q_desired    (q_desired),
        .loop_en      (loop_en),
        .loop_rst     (loop_rst),
        .step_idx     (step_idx),
        .step_done    (step_done),
        .step_timeout (step_timeout),
        .timeout_cnt  (timeout_cnt),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [9:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // entered just after the edge that moved the FSM into APPLY
    task automatic step_conv(input int exp_q, input int exp_idx, input int wait_n);
        tick();
        chk("apply_q", q_desired, exp_q);
        chk("apply_en", loop_en, 1);
        chk("apply_idx", step_idx, exp_idx);
        repeat (wait_n - 1) tick();
        chk("pre_done", step_done, 0);
        converged = 1'b1;
        tick();
        converged = 1'b0;
        chk("step_done", step_done, 1);
        chk("no_tmo", step_timeout, 0);
        repeat (3) tick();
        chk("rst_hi1", loop_rst, 1);
        chk("rst_en0", loop_en, 0);
        tick();
        chk("rst_hi2", loop_rst, 1);
        tick();
        chk("rst_lo", loop_rst, 0);
    endtask

    task automatic step_to(input int exp_q, input int exp_tc);
        tick();
        chk("to_q", q_desired, exp_q);
        repeat (19) tick();
        chk("to_early", step_timeout, 0);
        tick();
        chk("to_pulse", step_timeout, 1);
        chk("to_nodone", step_done, 0);
        chk("to_cnt", timeout_cnt, exp_tc);
        tick();
        chk("to_one_cyc", step_timeout, 0);
        repeat (2) tick();
        chk("to_rst1", loop_rst, 1);
        tick();
        chk("to_rst2", loop_rst, 1);
        tick();
        chk("to_rst_lo", loop_rst, 0);
    endtask

    initial begin
        int t0;
        int pulses;
        int cnt;
        int saw_en;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 10'd0;
        num_steps = 5'd0; go = 1'b0; abort = 1'b0; converged = 1'b0;
        repeat (2) tick();
        chk("rst_q", q_desired, 0);
        chk("rst_en", loop_en, 0);
        chk("rst_lrst", loop_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_tc", timeout_cnt, 0);
        rst = 1'b0;
        tick();

        // 1. basic sweep
        wr(4'd0, 10'd40); wr(4'd1, 10'd80); wr(4'd2, 10'd120);
        num_steps = 5'd3; go = 1'b1; tick(); go = 1'b0;
        t0 = cyc;
        chk("t1_busy", busy, 1);
        step_conv(40, 0, 6);
        step_conv(80, 1, 6);
        step_conv(120, 2, 6);
        chk("t1_cycles", cyc - t0, 36);
        chk("t1_done", done, 1);
        chk("t1_busy0", busy, 0);
        chk("t1_tc", timeout_cnt, 0);
        chk("t1_qhold", q_desired, 120);

        // 2. timeouts
        wr(4'd0, 10'd60); wr(4'd1, 10'd90);
        num_steps = 5'd2; go = 1'b1; tick(); go = 1'b0;
        chk("t2_done0", done, 0);
        step_to(60, 1);
        step_to(90, 2);
        chk("t2_done", done, 1);
        chk("t2_tc", timeout_cnt, 2);

        // 3. converge on the timeout cycle
        num_steps = 5'd1; go = 1'b1; tick(); go = 1'b0;
        tick();
        repeat (19) tick();
        converged = 1'b1;
        tick();
        converged = 1'b0;
        chk("t3_done_p", step_done, 1);
        chk("t3_tmo_p", step_timeout, 0);
        chk("t3_tc", timeout_cnt, 0);
        repeat (5) tick();
        chk("t3_done", done, 1);

        // 4. abort during HOLD of step 1
        wr(4'd0, 10'd10); wr(4'd1, 10'd20); wr(4'd2, 10'd30); wr(4'd3, 10'd40);
        num_steps = 5'd4; go = 1'b1; tick(); go = 1'b0;
        step_conv(10, 0, 6);
        tick();
        chk("t4_q", q_desired, 20);
        repeat (5) tick();
        converged = 1'b1; tick(); converged = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_rst1", loop_rst, 1);
        chk("t4_en0", loop_en, 0);
        chk("t4_nodone", step_done, 0);
        tick();
        chk("t4_rst2", loop_rst, 1);
        tick();
        chk("t4_rst_lo", loop_rst, 0);
        chk("t4_done", done, 1);
        chk("t4_idx", step_idx, 1);
        chk("t4_busy", busy, 0);
        saw_en = 0;
        repeat (5) begin
            tick();
            if (loop_en) saw_en++;
        end
        chk("t4_no_apply", saw_en, 0);
        chk("t4_qhold", q_desired, 20);

        // 5a. zero steps
        num_steps = 5'd0; go = 1'b1; tick(); go = 1'b0;
        chk("t5a_done", done, 1);
        chk("t5a_idx", step_idx, 0);
        chk("t5a_busy", busy, 0);
        saw_en = 0;
        repeat (3) begin
            tick();
            if (loop_en) saw_en++;
        end
        chk("t5a_en", saw_en, 0);

        // 5b. clamp 17 -> 16 steps, 7 cycles each with converged held high
        converged = 1'b1;
        num_steps = 5'd17; go = 1'b1; tick(); go = 1'b0;
        cnt = 0; pulses = 0;
        while (!done && cnt < 400) begin
            tick();
            cnt++;
            if (step_done) pulses++;
        end
        chk("t5b_cycles", cnt, 112);
        chk("t5b_pulses", pulses, 16);
        chk("t5b_idx", step_idx, 15);

        // 5c. table write while busy is dropped
        num_steps = 5'd2; go = 1'b1; tick(); go = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 10'd999;
        tick();
        cfg_we = 1'b0;
        chk("t5c_q0", q_desired, 10);
        repeat (7) tick();
        chk("t5c_idx", step_idx, 1);
        chk("t5c_q1", q_desired, 20);
        converged = 1'b0;
        cnt = 0;
        while (!done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("t5c_fin", done, 1);

        // 6. async reset during WAIT_CONV of step 1
        num_steps = 5'd2; go = 1'b1; tick(); go = 1'b0;
        tick();
        converged = 1'b1; tick(); converged = 1'b0;
        repeat (7) tick();
        chk("t6_pre_idx", step_idx, 1);
        chk("t6_pre_en", loop_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_q", q_desired, 0);
        chk("t6_en", loop_en, 0);
        chk("t6_idx", step_idx, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_lrst", loop_rst, 0);
        tick();
        rst = 1'b0;
        tick();
        num_steps = 5'd2; go = 1'b1; tick(); go = 1'b0;
        tick();
        chk("t6_re_idx", step_idx, 0);
        chk("t6_re_q", q_desired, 10);
        chk("t6_re_en", loop_en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
